cc_alu_sequencer: RTL and testbench

//  Command sequencer that owns the shared CC_ALU datapath.

---
 rtl/cc_alu_sequencer_pkg.sv | 37 +++
 rtl/cc_alu_seq_mulcore.sv | 54 +++++
 rtl/cc_alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cc_alu_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_alu_sequencer_pkg.sv
// Shared constants for the CC_ALU command sequencer: command opcodes,
// ALU selection codes, FSM state encoding and flag bit positions.
package cc_alu_sequencer_pkg;

   // Command opcodes
   localparam logic [1:0] CMD_SINGLE = 2'b00;
   localparam logic [1:0] CMD_MUL    = 2'b01;
   localparam logic [1:0] CMD_NEG    = 2'b10;
   localparam logic [1:0] CMD_RSVD   = 2'b11;

   // ALU selection codes used by the sequencer
   localparam logic [3:0] ALU_PASS = 4'b0000;
   localparam logic [3:0] ALU_NOT  = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b1000;
   localparam logic [3:0] ALU_INC  = 4'b1010;
   localparam logic [3:0] ALU_NOP  = 4'b1111;

   // Flag bit positions in {V,C,N,Z}; all flags are active-low
   localparam int unsigned FLAG_V = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   // All flags inactive
   localparam logic [3:0] FLAGS_NONE = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_MUL,
      ST_FLAGS,
      ST_NEG_NOT,
      ST_NEG_INC,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cc_alu_seq_mulcore.sv
// Shift-add multiplier state for the sequencer: partial product P,
// shifting multiplicand M, shifting multiplier Q and the sticky carry.
// The addition itself is performed by the shared ALU in the parent.
module cc_alu_seq_mulcore
   import cc_alu_sequencer_pkg::*;
#(
   parameter int unsigned DATAWIDTH_BUS = 32
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load,
   input  logic                     step,
   input  logic [DATAWIDTH_BUS-1:0] load_a,
   input  logic [DATAWIDTH_BUS-1:0] load_b,
   input  logic [DATAWIDTH_BUS-1:0] alu_data,
   input  logic                     alu_carry_n,
   output logic [DATAWIDTH_BUS-1:0] p,
   output logic [DATAWIDTH_BUS-1:0] m,
   output logic                     q_lsb,
   output logic                     last,
   output logic                     sticky
);

   logic [DATAWIDTH_BUS-1:0] q;

   // One multiply iteration per step; load initialises the operands
   always_ff @(posedge clk) begin
      if (reset) begin
         p      <= '0;
         m      <= '0;
         q      <= '0;
         sticky <= 1'b0;
      end else if (load) begin
         p      <= '0;
         m      <= load_a;
         q      <= load_b;
         sticky <= 1'b0;
      end else if (step) begin
         if (q[0]) begin
            p      <= alu_data;
            sticky <= sticky | ~alu_carry_n;
         end
         m <= m << 1;
         q <= q >> 1;
      end
   end

   // Exit when the shifted multiplier would become zero
   always_comb begin
      q_lsb = q[0];
      last  = (q[DATAWIDTH_BUS-1:1] == '0);
   end

endmodule

// File: rtl/cc_alu_sequencer.sv
// Command sequencer owning the shared CC_ALU datapath. Accepts one command
// at a time, runs single-cycle ops directly and MUL/NEG as multi-cycle ALU
// sequences, then holds the result on a valid/ready response channel.
module cc_alu_sequencer
   import cc_alu_sequencer_pkg::*;
#(
   parameter int unsigned DATAWIDTH_BUS           = 32,
   parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
   parameter int unsigned DATAWIDTH_CMD           = 2
)(
   input  logic                               CC_ALUSEQ_CLOCK_50,
   input  logic                               CC_ALUSEQ_RESET_InHigh,
   input  logic                               CC_ALUSEQ_cmdValid_In,
   output logic                               CC_ALUSEQ_cmdReady_Out,
   input  logic [DATAWIDTH_CMD-1:0]           CC_ALUSEQ_cmdOp_InBUS,
   input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_cmdSel_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_cmdDataA_InBUS,
   input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_cmdDataB_InBUS,
   output logic                               CC_ALUSEQ_rspValid_Out,
   input  logic                               CC_ALUSEQ_rspReady_In,
   output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_rspData_OutBUS,
   output logic [3:0]                         CC_ALUSEQ_rspFlags_OutBUS,
   output logic                               CC_ALUSEQ_rspError_Out,
   output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_aluSel_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataA_OutBUS,
   output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataB_OutBUS,
   input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluData_InBUS,
   input  logic [3:0]                         CC_ALUSEQ_aluFlags_InBUS
);

   state_t                             state;
   logic [DATAWIDTH_BUS-1:0]           a_r;
   logic [DATAWIDTH_BUS-1:0]           b_r;
   logic [DATAWIDTH_ALU_SELECTION-1:0] sel_r;

   logic                               accept;
   logic                               mul_load;
   logic                               mul_step;
   logic [DATAWIDTH_BUS-1:0]           mul_p;
   logic [DATAWIDTH_BUS-1:0]           mul_m;
   logic                               mul_q_lsb;
   logic                               mul_last;
   logic                               mul_sticky;

   // Handshake decode: ready only in IDLE
   always_comb begin
      CC_ALUSEQ_cmdReady_Out = (state == ST_IDLE);
      accept   = CC_ALUSEQ_cmdValid_In && (state == ST_IDLE);
      mul_load = accept && (CC_ALUSEQ_cmdOp_InBUS == CMD_MUL);
      mul_step = (state == ST_MUL);
   end

   cc_alu_seq_mulcore #(
      .DATAWIDTH_BUS (DATAWIDTH_BUS)
   ) u_mulcore (
      .clk         (CC_ALUSEQ_CLOCK_50),
      .reset       (CC_ALUSEQ_RESET_InHigh),
      .load        (mul_load),
      .step        (mul_step),
      .load_a      (CC_ALUSEQ_cmdDataA_InBUS),
      .load_b      (CC_ALUSEQ_cmdDataB_InBUS),
      .alu_data    (CC_ALUSEQ_aluData_InBUS),
      .alu_carry_n (CC_ALUSEQ_aluFlags_InBUS[FLAG_C]),
      .p           (mul_p),
      .m           (mul_m),
      .q_lsb       (mul_q_lsb),
      .last        (mul_last),
      .sticky      (mul_sticky)
   );

   // Sequencer FSM with registered response outputs
   always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
      if (CC_ALUSEQ_RESET_InHigh) begin
         state                     <= ST_IDLE;
         a_r                       <= '0;
         b_r                       <= '0;
         sel_r                     <= '0;
         CC_ALUSEQ_rspValid_Out    <= 1'b0;
         CC_ALUSEQ_rspData_OutBUS  <= '0;
         CC_ALUSEQ_rspFlags_OutBUS <= FLAGS_NONE;
         CC_ALUSEQ_rspError_Out    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_r   <= CC_ALUSEQ_cmdDataA_InBUS;
                  b_r   <= CC_ALUSEQ_cmdDataB_InBUS;
                  sel_r <= CC_ALUSEQ_cmdSel_InBUS;
                  case (CC_ALUSEQ_cmdOp_InBUS)
                     CMD_SINGLE: state <= ST_EXEC;
                     CMD_MUL:    state <= ST_MUL;
                     CMD_NEG:    state <= ST_NEG_NOT;
                     default: begin
                        state                     <= ST_DONE;
                        CC_ALUSEQ_rspValid_Out    <= 1'b1;
                        CC_ALUSEQ_rspData_OutBUS  <= '0;
                        CC_ALUSEQ_rspFlags_OutBUS <= FLAGS_NONE;
                        CC_ALUSEQ_rspError_Out    <= 1'b1;
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               state                     <= ST_DONE;
               CC_ALUSEQ_rspValid_Out    <= 1'b1;
               CC_ALUSEQ_rspData_OutBUS  <= CC_ALUSEQ_aluData_InBUS;
               CC_ALUSEQ_rspFlags_OutBUS <= CC_ALUSEQ_aluFlags_InBUS;
               CC_ALUSEQ_rspError_Out    <= 1'b0;
            end
            ST_MUL: begin
               if (mul_last) state <= ST_FLAGS;
            end
            ST_FLAGS: begin
               state                     <= ST_DONE;
               CC_ALUSEQ_rspValid_Out    <= 1'b1;
               CC_ALUSEQ_rspData_OutBUS  <= mul_p;
               CC_ALUSEQ_rspFlags_OutBUS <= {1'b1, ~mul_sticky,
                                             CC_ALUSEQ_aluFlags_InBUS[FLAG_N],
                                             CC_ALUSEQ_aluFlags_InBUS[FLAG_Z]};
               CC_ALUSEQ_rspError_Out    <= 1'b0;
            end
            ST_NEG_NOT: begin
               // The inverted operand overwrites A; it feeds the increment step
               a_r   <= CC_ALUSEQ_aluData_InBUS;
               state <= ST_NEG_INC;
            end
            ST_NEG_INC: begin
               state                     <= ST_DONE;
               CC_ALUSEQ_rspValid_Out    <= 1'b1;
               CC_ALUSEQ_rspData_OutBUS  <= CC_ALUSEQ_aluData_InBUS;
               CC_ALUSEQ_rspFlags_OutBUS <= CC_ALUSEQ_aluFlags_InBUS;
               CC_ALUSEQ_rspError_Out    <= 1'b0;
            end
            ST_DONE: begin
               if (CC_ALUSEQ_rspReady_In) begin
                  state                  <= ST_IDLE;
                  CC_ALUSEQ_rspValid_Out <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ALU drive decoded from the current state and operand registers
   always_comb begin
      CC_ALUSEQ_aluSel_OutBUS   = ALU_NOP;
      CC_ALUSEQ_aluDataA_OutBUS = '0;
      CC_ALUSEQ_aluDataB_OutBUS = '0;
      case (state)
         ST_EXEC: begin
            CC_ALUSEQ_aluSel_OutBUS   = sel_r;
            CC_ALUSEQ_aluDataA_OutBUS = a_r;
            CC_ALUSEQ_aluDataB_OutBUS = b_r;
         end
         ST_MUL: begin
            if (mul_q_lsb) begin
               CC_ALUSEQ_aluSel_OutBUS   = ALU_ADD;
               CC_ALUSEQ_aluDataA_OutBUS = mul_p;
               CC_ALUSEQ_aluDataB_OutBUS = mul_m;
            end
         end
         ST_FLAGS: begin
            CC_ALUSEQ_aluSel_OutBUS   = ALU_PASS;
            CC_ALUSEQ_aluDataA_OutBUS = mul_p;
         end
         ST_NEG_NOT: begin
            CC_ALUSEQ_aluSel_OutBUS   = ALU_NOT;
            CC_ALUSEQ_aluDataA_OutBUS = a_r;
         end
         ST_NEG_INC: begin
            CC_ALUSEQ_aluSel_OutBUS   = ALU_INC;
            CC_ALUSEQ_aluDataA_OutBUS = a_r;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cc_alu_sequencer.sv
// Testbench for cc_alu_sequencer with a behavioural CC_ALU alongside it.
module tb_cc_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [3:0]  cmd_sel = 4'b0000;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic        rsp_error;
   logic [3:0]  alu_sel;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_data;
   logic [3:0]  alu_flags;

   int total = 0;
   int bad = 0;

   always #10 clk = ~clk;

   cc_alu_sequencer #(
      .DATAWIDTH_BUS           (32),
      .DATAWIDTH_ALU_SELECTION (4),
      .DATAWIDTH_CMD           (2)
   ) dut (
      .CC_ALUSEQ_CLOCK_50        (clk),
      .CC_ALUSEQ_RESET_InHigh    (reset),
      .CC_ALUSEQ_cmdValid_In     (cmd_valid),
      .CC_ALUSEQ_cmdReady_Out    (cmd_ready),
      .CC_ALUSEQ_cmdOp_InBUS     (cmd_op),
      .CC_ALUSEQ_cmdSel_InBUS    (cmd_sel),
      .CC_ALUSEQ_cmdDataA_InBUS  (cmd_a),
      .CC_ALUSEQ_cmdDataB_InBUS  (cmd_b),
      .CC_ALUSEQ_rspValid_Out    (rsp_valid),
      .CC_ALUSEQ_rspReady_In     (rsp_ready),
      .CC_ALUSEQ_rspData_OutBUS  (rsp_data),
      .CC_ALUSEQ_rspFlags_OutBUS (rsp_flags),
      .CC_ALUSEQ_rspError_Out    (rsp_error),
      .CC_ALUSEQ_aluSel_OutBUS   (alu_sel),
      .CC_ALUSEQ_aluDataA_OutBUS (alu_a),
      .CC_ALUSEQ_aluDataB_OutBUS (alu_b),
      .CC_ALUSEQ_aluData_InBUS   (alu_data),
      .CC_ALUSEQ_aluFlags_InBUS  (alu_flags)
   );

   // Behavioural CC_ALU: returns {flags{V,C,N,Z} active-low, result}
   function automatic logic [35:0] alu_fn(input logic [3:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic v, c;
      v = 1'b0; c = 1'b0; s = '0;
      case (sel)
         4'b0000: s = {1'b0, a};
         4'b0001: s = {1'b0, a | b};
         4'b0010: s = {1'b0, a & b};
         4'b0011: s = {1'b0, ~a};
         4'b0100: s = {1'b0, a ^ b};
         4'b1000: begin
            s = {1'b0, a} + {1'b0, b};
            c = s[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
         end
         4'b1010: begin
            s = {1'b0, a} + 33'd1;
            c = (a == 32'hFFFF_FFFF);
            v = (a == 32'h7FFF_FFFF);
         end
         default: return {4'b1111, 32'h0};
      endcase
      return {~v, ~c, ~s[31], (s[31:0] != 32'h0), s[31:0]};
   endfunction

   always_comb {alu_flags, alu_data} = alu_fn(alu_sel, alu_a, alu_b);

   // Reference model of a whole command: result, flags, error, edges to response
   task automatic model(input logic [1:0] op, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic [3:0] f,
                        output logic e, output int lat);
      logic [63:0] prod;
      logic [32:0] acc;
      logic [31:0] sh;
      logic sticky;
      int nb;
      e = 1'b0;
      case (op)
         2'b00: begin
            {f, d} = alu_fn(sel, a, b);
            lat = 1;
         end
         2'b01: begin
            prod = {32'h0, a} * {32'h0, b};
            d = prod[31:0];
            acc = '0; sticky = 1'b0; nb = 0;
            for (int i = 0; i < 32; i++) begin
               if (b[i]) begin
                  sh = a << i;
                  acc = {1'b0, acc[31:0]} + {1'b0, sh};
                  sticky |= acc[32];
                  nb = i + 1;
               end
            end
            f = {1'b1, ~sticky, ~d[31], (d != 32'h0)};
            lat = ((nb == 0) ? 1 : nb) + 1;
         end
         2'b10: begin
            d = 32'h0 - a;
            f = {(a != 32'h8000_0000), (a != 32'h0), ~d[31], (d != 32'h0)};
            lat = 2;
         end
         default: begin
            d = 32'h0; f = 4'b1111; e = 1'b1; lat = 0;
         end
      endcase
   endtask

   // Drives one command, waits for the response, stalls, then consumes it
   task automatic do_cmd(input logic [1:0] op, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b, input int stall,
                         output logic [31:0] d, output logic [3:0] f, output logic e,
                         output int lat, output bit timeout, output bit stable,
                         output bit released);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_a = a; cmd_b = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom); cmd_sel = 4'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      timeout = !rsp_valid;
      d = rsp_data; f = rsp_flags; e = rsp_error;
      stable = 1'b1;
      cmd_valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         if (rsp_data !== d || rsp_flags !== f || rsp_error !== e ||
             rsp_valid !== 1'b1 || cmd_ready !== 1'b0) stable = 1'b0;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      released = (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if ({rsp_valid, rsp_data, rsp_flags, rsp_error, cmd_ready} !== {1'b0, 32'h0, 4'b1111, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b data=%h flags=%b err=%b ready=%b, want 0 0 1111 0 1",
                  rsp_valid, rsp_data, rsp_flags, rsp_error, cmd_ready);
      end
      total++;
      if ({alu_sel, alu_a, alu_b} !== {4'b1111, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL reset_alu_idle: got sel=%b a=%h b=%h, want 1111 0 0", alu_sel, alu_a, alu_b);
      end
   endtask

   task automatic test_single();
      logic [31:0] d; logic [3:0] f; logic e; int lat; bit to, st, rl;
      do_cmd(2'b00, 4'b1000, 32'h7FFF_FFFF, 32'h1, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'h8000_0000 || f !== 4'b0101 || e !== 1'b0) begin
         bad++;
         $display("FAIL single_add: got data=%h flags=%b err=%b timeout=%b, want 80000000 0101 0 0", d, f, e, to);
      end
      total++;
      if (lat != 1) begin
         bad++;
         $display("FAIL single_latency: got %0d, want 1", lat);
      end
      total++;
      if (!rl) begin
         bad++;
         $display("FAIL single_release: got valid=%b ready=%b, want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_mul();
      logic [31:0] d; logic [3:0] f; logic e; int lat; bit to, st, rl;
      do_cmd(2'b01, 4'b0000, 32'd6, 32'd7, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'd42 || f !== 4'b1111 || lat != 4) begin
         bad++;
         $display("FAIL mul_6x7: got data=%0d flags=%b lat=%0d, want 42 1111 4", d, f, lat);
      end
      do_cmd(2'b01, 4'b0000, 32'd9, 32'd0, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'd0 || f !== 4'b1110 || lat != 2) begin
         bad++;
         $display("FAIL mul_by_zero: got data=%0d flags=%b lat=%0d, want 0 1110 2", d, f, lat);
      end
   endtask

   task automatic test_neg();
      logic [31:0] d; logic [3:0] f; logic e; int lat; bit to, st, rl;
      do_cmd(2'b10, 4'b0000, 32'd5, 32'd0, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'hFFFF_FFFB || f[1] !== 1'b0 || f[0] !== 1'b1 || lat != 2) begin
         bad++;
         $display("FAIL neg_5: got data=%h flags=%b lat=%0d, want FFFFFFFB N=0 Z=1 2", d, f, lat);
      end
      do_cmd(2'b10, 4'b0000, 32'd0, 32'd0, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'h0 || f[0] !== 1'b0) begin
         bad++;
         $display("FAIL neg_0: got data=%h flags=%b, want 0 Z=0", d, f);
      end
   endtask

   task automatic test_reserved();
      logic [31:0] d; logic [3:0] f; logic e; int lat; bit to, st, rl;
      do_cmd(2'b11, 4'b0100, 32'h1234, 32'h5678, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || e !== 1'b1 || d !== 32'h0 || f !== 4'b1111) begin
         bad++;
         $display("FAIL reserved_op: got err=%b data=%h flags=%b, want 1 0 1111", e, d, f);
      end
      do_cmd(2'b00, 4'b0100, 32'hF0, 32'hFF, 0, d, f, e, lat, to, st, rl);
      total++;
      if (to || e !== 1'b0 || d !== 32'h0F) begin
         bad++;
         $display("FAIL after_reserved: got err=%b data=%h, want 0 0000000f", e, d);
      end
   endtask

   task automatic test_stall();
      logic [31:0] d; logic [3:0] f; logic e; int lat; bit to, st, rl;
      do_cmd(2'b00, 4'b0001, 32'h0F, 32'hF0, 3, d, f, e, lat, to, st, rl);
      total++;
      if (to || d !== 32'hFF) begin
         bad++;
         $display("FAIL stall_data: got %h, want 000000ff", d);
      end
      total++;
      if (!st) begin
         bad++;
         $display("FAIL stall_hold: got unstable response or cmdReady high, want stable with cmdReady=0");
      end
      total++;
      if (!rl) begin
         bad++;
         $display("FAIL stall_release: got valid=%b ready=%b, want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      bit seen;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 32'hFF; cmd_b = 32'hFF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total++;
      if ({rsp_valid, rsp_data, rsp_flags, rsp_error, cmd_ready} !== {1'b0, 32'h0, 4'b1111, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL midreset_outputs: got valid=%b data=%h flags=%b err=%b ready=%b, want 0 0 1111 0 1",
                  rsp_valid, rsp_data, rsp_flags, rsp_error, cmd_ready);
      end
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || alu_sel !== 4'b1111) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL midreset_no_response: got activity after abort, want idle");
      end
   endtask

   task automatic test_random();
      logic [3:0] sels [6];
      logic [1:0] op; logic [3:0] sel; logic [31:0] a, b;
      logic [31:0] d, ed; logic [3:0] f, ef; logic e, ee; int lat, el; bit to, st, rl;
      sels = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b1000, 4'b1010};
      for (int n = 0; n < 40; n++) begin
         op  = 2'($urandom_range(0, 3));
         sel = sels[$urandom_range(0, 5)];
         a   = $urandom;
         b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300));
         if (n % 7 == 0) a = 32'h8000_0000;
         model(op, sel, a, b, ed, ef, ee, el);
         do_cmd(op, sel, a, b, $urandom_range(0, 2), d, f, e, lat, to, st, rl);
         total++;
         if (to || d !== ed || f !== ef || e !== ee || lat != el || !st || !rl) begin
            bad++;
            $display("FAIL random_%0d op=%b sel=%b a=%h b=%h: got data=%h flags=%b err=%b lat=%0d stable=%b rel=%b, want %h %b %b %0d 1 1",
                     n, op, sel, a, b, d, f, e, lat, st, rl, ed, ef, ee, el);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_mul();
      test_neg();
      test_reserved();
      test_stall();
      test_reset_mid_mul();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
